buzzer_melody_seq: RTL

Sequencer that plays a melody through the square-wave buzzer generator. It walks a synchronous song ROM of {note_div, duration} entries and drives the buzzer's 22-bit note divider plus a mute gate. Note length is counted in beats, and a short silent gap separates notes. Sits between the top-level control (buttons/FSM) and the buzzer/audio DAC path.

---
 rtl/buzzer_melody_if.sv | 26 ++
 rtl/buzzer_melody_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/buzzer_melody_if.sv
// Melody sequencer bus: playback control, song ROM port and buzzer drive.
// master = the sequencer, slave = the surrounding control / ROM / buzzer side.
interface buzzer_melody_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [29:0]       rom_data;
  logic [21:0]       note_div;
  logic              mute;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, pause, loop_en, rom_data,
    output rom_addr, note_div, mute, busy, done
  );

  modport slave (
    output start, stop, pause, loop_en, rom_data,
    input  rom_addr, note_div, mute, busy, done
  );
endinterface

// File: rtl/buzzer_melody_seq.sv
// Melody sequencer: walks a synchronous song ROM of {note_div, dur} words,
// drives the buzzer divider and a mute gate, counts note length in beats and
// inserts a silent gap between notes.
module buzzer_melody_seq #(
  parameter int ADDR_W   = 8,
  parameter int BEAT_DIV = 12500000,
  parameter int GAP_CYC  = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  buzzer_melody_if.master bus
);

  localparam int CYC_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BEAT_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [21:0]       note_div_q, note_div_d;
  logic              mute_q, mute_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rest_q, rest_d;
  logic [7:0]        dur_q, dur_d;
  logic [7:0]        beat_q, beat_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [21:0] rom_div;
  logic [7:0]  rom_dur;

  assign rom_div = bus.rom_data[29:8];
  assign rom_dur = bus.rom_data[7:0];

  // Next-state and output decode: stop beats pause beats normal sequencing.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    note_div_d = note_div_q;
    mute_d     = mute_q;
    done_d     = 1'b0;
    rest_d     = rest_q;
    dur_d      = dur_q;
    beat_d     = beat_q;
    cyc_d      = cyc_q;
    gap_d      = gap_q;

    if (bus.stop) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      note_div_d = '0;
      mute_d     = 1'b1;
      beat_d     = '0;
      cyc_d      = '0;
      gap_d      = '0;
    end else if (bus.pause && (state_q != S_IDLE)) begin
      // Everything frozen; only the audio is gated.
      mute_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          mute_d = 1'b1;
          if (bus.start) begin
            state_d    = S_FETCH;
            rom_addr_d = '0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (rom_dur == 8'd0) begin
            rom_addr_d = '0;
            if (bus.loop_en) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              mute_d  = 1'b1;
            end
          end else begin
            note_div_d = rom_div;
            rest_d     = (rom_div == 22'd0);
            mute_d     = (rom_div == 22'd0);
            dur_d      = rom_dur;
            beat_d     = '0;
            cyc_d      = '0;
            state_d    = S_PLAY;
          end
        end
        S_PLAY: begin
          mute_d = rest_q;
          if (cyc_q == CYC_LAST) begin
            cyc_d  = '0;
            beat_d = beat_q + 8'd1;
            if ((beat_q + 8'd1) == dur_q) begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              mute_d     = 1'b1;
              gap_d      = '0;
              state_d    = (GAP_CYC == 0) ? S_FETCH : S_GAP;
            end
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
        S_GAP: begin
          mute_d = 1'b1;
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = S_FETCH;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      note_div_q <= '0;
      mute_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rest_q     <= 1'b0;
      dur_q      <= '0;
      beat_q     <= '0;
      cyc_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      note_div_q <= note_div_d;
      mute_q     <= mute_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rest_q     <= rest_d;
      dur_q      <= dur_d;
      beat_q     <= beat_d;
      cyc_q      <= cyc_d;
      gap_q      <= gap_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.note_div = note_div_q;
  assign bus.mute     = mute_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
